// File: rtl/man_pkg.sv
// Shared types and sizing helpers for the Manchester frame encoder.
// MAN_PARITY_EN (in the users of this package) enables the per-word odd-parity bit.
package man_pkg;

    typedef enum logic [2:0] {IDLE, SOF, DATA, PAR, EOF} state_t;

    localparam int DEF_DATA_W   = 8;
    localparam int DEF_HALF_ETU = 4;
    localparam int ETU_CLKS     = 2 * DEF_HALF_ETU;
    localparam int CNT_W        = $clog2(DEF_HALF_ETU) + 1;
    localparam int BIT_W        = $clog2(DEF_DATA_W) + 1;

    // Widths recomputed for parameter overrides in the instantiating modules
    function automatic int cnt_width(input int half_etu);
        return $clog2(half_etu) + 1;
    endfunction

    function automatic int bit_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/man_etu_timer.sv
// Half-ETU timer: counts clocks inside each half bit and flags half/ETU boundaries.
// pre_end marks the clock before the last clock of an ETU so registered outputs can lead it.
module man_etu_timer
    import man_pkg::*;
#(
    parameter int HALF_ETU = DEF_HALF_ETU
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic run,
    output logic half,
    output logic half_tick,
    output logic etu_end,
    output logic pre_end
);

    localparam int CW = cnt_width(HALF_ETU);
    localparam logic [CW-1:0] TOP_CNT = CW'(HALF_ETU - 1);
    localparam logic [CW-1:0] PRE_CNT = (HALF_ETU > 1) ? CW'(HALF_ETU - 2) : '0;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            half <= 1'b0;
        end else if (clear || !run) begin
            cnt  <= '0;
            half <= 1'b0;
        end else if (cnt == TOP_CNT) begin
            cnt  <= '0;
            half <= ~half;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // With a one-clock half, the ETU's first clock is already the one before its end
    always_comb begin
        half_tick = run && (cnt == TOP_CNT);
        etu_end   = half_tick && half;
        if (HALF_ETU == 1) begin
            pre_end = run && !half;
        end else begin
            pre_end = run && half && (cnt == PRE_CNT);
        end
    end

endmodule

// File: rtl/man_frame_tx.sv
// Manchester frame encoder: SOF, data bits (optional odd parity per word), one idle ETU.
// Define MAN_PARITY_EN to append a parity bit after each word.
module man_frame_tx
    import man_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int HALF_ETU  = DEF_HALF_ETU,
    parameter int LSB_FIRST = 1
) (
    input  logic              clk,
    input  logic              in_rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_pol,
    output logic              in_ready,
    output logic              out_data,
    output logic              out_en,
    output logic              out_busy,
    output logic              out_underrun
);

    localparam int IW = bit_width(DATA_W);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_W - 1);

    state_t            state, state_n;
    logic [IW-1:0]     bit_idx, bit_idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              last_q, last_n;
    logic              pol_q, pol_n;
    logic              urun_n, ready_n, data_n, half_n, cur_bit;
    logic              accept, start, final_bit, eow;
    logic              half, half_tick, etu_end, pre_end;
`ifdef MAN_PARITY_EN
    logic              par_q, par_n;
`endif

    man_etu_timer #(.HALF_ETU(HALF_ETU)) timer (
        .clk       (clk),
        .rst_n     (in_rst_n),
        .clear     (start),
        .run       (state != IDLE),
        .half      (half),
        .half_tick (half_tick),
        .etu_end   (etu_end),
        .pre_end   (pre_end)
    );

    assign accept = in_valid && in_ready;
    assign start  = accept && (state == IDLE);
`ifdef MAN_PARITY_EN
    assign final_bit = (state == PAR);
`else
    assign final_bit = (state == DATA) && (bit_idx == LAST_IDX);
`endif
    assign eow = etu_end && final_bit;

    // Outputs are registered from the next-cycle view of state, bit and half
    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        last_n    = last_q;
        pol_n     = pol_q;
        urun_n    = out_underrun;
`ifdef MAN_PARITY_EN
        par_n     = par_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = SOF;
                    bit_idx_n = '0;
                    shreg_n   = in_data;
                    last_n    = in_last;
                    pol_n     = in_pol;
                    urun_n    = 1'b0;
`ifdef MAN_PARITY_EN
                    par_n     = ~^in_data;
`endif
                end
            end
            SOF: begin
                if (etu_end) begin
                    state_n   = DATA;
                    bit_idx_n = '0;
                end
            end
            DATA: begin
                if (etu_end && !final_bit) begin
`ifdef MAN_PARITY_EN
                    if (bit_idx == LAST_IDX) begin
                        state_n = PAR;
                    end else
`endif
                    begin
                        bit_idx_n = bit_idx + IW'(1);
                        shreg_n   = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);
                    end
                end
            end
            EOF: begin
                if (etu_end) begin
                    state_n = IDLE;
                end
            end
            default: begin
            end
        endcase

        // Chain the next word with no gap, or close the frame (truncated if none arrived)
        if (eow) begin
            if (accept && !last_q) begin
                state_n   = DATA;
                bit_idx_n = '0;
                shreg_n   = in_data;
                last_n    = in_last;
`ifdef MAN_PARITY_EN
                par_n     = ~^in_data;
`endif
            end else begin
                state_n = EOF;
                if (!last_q) begin
                    urun_n = 1'b1;
                end
            end
        end

        half_n  = (start || state_n == IDLE) ? 1'b0 : (half ^ half_tick);
        cur_bit = (LSB_FIRST != 0) ? shreg_n[0] : shreg_n[DATA_W-1];

        data_n = 1'b0;
        case (state_n)
            SOF:     data_n = 1'b1 ^ pol_n ^ half_n;
            DATA:    data_n = cur_bit ^ pol_n ^ half_n;
`ifdef MAN_PARITY_EN
            PAR:     data_n = par_n ^ pol_n ^ half_n;
`endif
            default: data_n = 1'b0;
        endcase

        ready_n = (state_n == IDLE) || (pre_end && final_bit && !last_q);
    end

    always_ff @(posedge clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state        <= IDLE;
            bit_idx      <= '0;
            shreg        <= '0;
            last_q       <= 1'b0;
            pol_q        <= 1'b0;
`ifdef MAN_PARITY_EN
            par_q        <= 1'b0;
`endif
            in_ready     <= 1'b0;
            out_data     <= 1'b0;
            out_en       <= 1'b0;
            out_busy     <= 1'b0;
            out_underrun <= 1'b0;
        end else begin
            state        <= state_n;
            bit_idx      <= bit_idx_n;
            shreg        <= shreg_n;
            last_q       <= last_n;
            pol_q        <= pol_n;
`ifdef MAN_PARITY_EN
            par_q        <= par_n;
`endif
            in_ready     <= ready_n;
            out_data     <= data_n;
            out_en       <= (state_n != IDLE);
            out_busy     <= (state_n != IDLE);
            out_underrun <= urun_n;
        end
    end

endmodule
